rr_trace_unpacker: RTL and testbench
====================================

// Module: rr_trace_unpacker
// PURPOSE
//  Replay-side decoder for the record/replay trace: accepts the densely bit-packed trace stream
//  (AXI_WIDTH beats, as fetched from host memory by the trace read path) and re-cuts it into
//  variable-width packets {payloads, LOGE bits, LOGB bitmap}, each with its width, for the replay
//  dispatcher. Exact inverse of the record-side packer.
// PARAMETERS
//  WIDTH             1247   max packet width = LOGB+LOGE+sum(CHANNEL_WIDTHS)
//  OFFSET_WIDTH      $clog2(WIDTH-1)+1   width field size
//  AXI_WIDTH         512    input beat width
//  LOGB_CHANNEL_CNT  14     bitmap bits, packet bits [LOGB-1:0]
//  LOGE_CHANNEL_CNT  25     logE bits, packet bits [LOGB +: LOGE]
//  CHANNEL_WIDTHS    {..}   [LOGB][RR_CHANNEL_WIDTH_BITS] payload width per bitmap bit (shuffled order)
// PORTS
//  clk        in   1             clock
//  rst        in   1             async reset, active high
//  in_data    in   AXI_WIDTH     trace beat, stream bit 0 = in_data[0]
//  in_valid   in   1             beat valid
//  in_ready   out  1             beat accepted when in_valid&&in_ready
//  in_last    in   1             final beat of trace
//  out_data   out  WIDTH         packet, bits >= out_width are zero
//  out_width  out  OFFSET_WIDTH  packet length in bits
//  out_valid  out  1             packet valid
//  out_ready  in   1             packet consumed when out_valid&&out_ready
//  done       out  1             1-cycle pulse: trace fully drained
//  pkt_count  out  32            [RR_UNPACK_STATS_EN only] packets emitted since reset
//  trunc_err  out  1             [RR_UNPACK_STATS_EN only] sticky truncation/format error
// BEHAVIOUR
//  - HDR=LOGB+LOGE. Stream is contiguous across beats, LSB first; payloads follow header in
//    ascending bitmap index. len = HDR + sum(CHANNEL_WIDTHS[i] for bitmap[i]).
//  - Buffer buf[BUF_W-1:0], BUF_W=WIDTH+AXI_WIDTH; fill counter $clog2(BUF_W+1) bits.
//  - States RUN, DRAIN. Reset: state=RUN, fill=0, out_valid=0, out_data=0, out_width=0, done=0,
//    pkt_count=0, trunc_err=0. Async reset mid-packet discards everything.
//  - in_ready = (state==RUN) && (fill <= BUF_W-AXI_WIDTH); combinational on registers only.
//  - pop_ok = fill>=HDR && bitmap!=0 || loge!=0 (nonzero header) && fill>=len && (!out_valid||out_ready).
//  - Pop: out_data <= buf & mask(len), out_width <= len, out_valid <= 1; buf >>= len; fill -= len.
//    Latency: complete packet in buf -> out_valid next cycle. One packet per cycle max.
//  - Accept: beat written at bit position (fill - popped_len); same-cycle pop+accept legal,
//    fill' = fill - len + AXI_WIDTH. in_last accepted -> DRAIN.
//  - Zero header in RUN (fill>=HDR): drop HDR bits, set trunc_err (stats build).
//  - DRAIN: pop remaining packets; when no pop possible (fill<HDR, zero header, or fill<len):
//    fill<=0, done pulse, state<=RUN. Partial packet (nonzero header, fill<len) flags trunc_err.
//    Zero/short padding tail is legal, no error.
//  - out_valid clears on out_ready with no new pop; out_data/out_width held while stalled.
// CONFIGURATION
//  `RR_UNPACK_STATS_EN defined: pkt_count increments per pop (wraps at 2^32); trunc_err sticky
//  until rst. Undefined: both ports absent, no counters synthesized; behaviour otherwise identical.
// STRUCTURE
//  rr_trace_pkg: RR_CHANNEL_WIDTH_BITS, state enum rr_unpack_state_e, function
//  rr_pkt_len(bitmap, widths) shared with record packer and benches.
//  Sub-module rr_pkt_len_calc: combinational bitmap -> len (adder tree), registered by parent.
// TESTING  (cfg: AXI_WIDTH=32, LOGB=2, LOGE=2, CHANNEL_WIDTHS[0]=4, [1]=40, WIDTH=48)
//  1 beat 32'hA1A1A1A1, in_last=1 -> 4 packets width 8 data 8'hA1 on consecutive cycles, then done.
//  2 packet bitmap=2'b10 (len 44) split across 2 beats -> single out_width=44 after 2nd beat accept.
//  3 out_ready=0 for 20 cycles under continuous beats -> in_ready drops at fill>48, no packet lost/dup.
//  4 last beat ends with 4 zero pad bits after full packets -> pad discarded, done, trunc_err=0.
//  5 last beat ends with header 4'b0010 + 8 payload bits -> packet dropped, done, trunc_err=1.
//  6 rst pulse mid-spanning packet -> all outputs 0 next cycle; test 1 replayed decodes correctly.

Source files
------------

// File: rtl/rr_trace_pkg.sv
// rr_trace_pkg: definitions shared by the record-side packer, the replay-side
// unpacker and their benches.
//   RR_CHANNEL_WIDTH_BITS  bits per entry of a CHANNEL_WIDTHS table
//   rr_unpack_state_e      unpacker control states
//   rr_pkt_len()           payload length selected by a bitmap (header excluded)
package rr_trace_pkg;

  localparam int RR_CHANNEL_WIDTH_BITS = 11;
  localparam int RR_MAX_CHANNELS       = 32;
  localparam int RR_LEN_BITS           = 16;

  typedef enum logic [0:0] {
    RR_RUN   = 1'b0,
    RR_DRAIN = 1'b1
  } rr_unpack_state_e;

  typedef logic [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_width_table_t;

  // Sum of the widths of every channel whose bitmap bit is set. Callers
  // zero-extend their bitmap and width table to RR_MAX_CHANNELS entries.
  function automatic logic [RR_LEN_BITS-1:0] rr_pkt_len(
    input logic [RR_MAX_CHANNELS-1:0] bitmap,
    input rr_width_table_t            widths
  );
    logic [RR_LEN_BITS-1:0] sum;
    sum = '0;
    for (int i = 0; i < RR_MAX_CHANNELS; i++) begin
      if (bitmap[i]) sum = sum + RR_LEN_BITS'(widths[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/rr_pkt_len_calc.sv
// rr_pkt_len_calc: combinational packet length from a header bitmap.
//   bitmap  in   LOGB_CHANNEL_CNT  bitmap field of the packet header
//   len     out  OFFSET_WIDTH      LOGB + LOGE + widths of the selected channels
// The summation is written as a chain; synthesis rebalances it into a tree.
module rr_pkt_len_calc
  import rr_trace_pkg::*;
#(
  parameter int LOGB_CHANNEL_CNT = 14,
  parameter int LOGE_CHANNEL_CNT = 25,
  parameter int OFFSET_WIDTH     = 12,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = '0
) (
  input  logic [LOGB_CHANNEL_CNT-1:0] bitmap,
  output logic [OFFSET_WIDTH-1:0]     len
);

  localparam logic [RR_LEN_BITS-1:0] HDR_LEN = RR_LEN_BITS'(LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT);

  rr_width_table_t        widths;
  logic [RR_LEN_BITS-1:0] payload;

  always_comb begin
    widths = '0;
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) widths[i] = CHANNEL_WIDTHS[i];
    payload = rr_pkt_len(RR_MAX_CHANNELS'(bitmap), widths);
    len     = OFFSET_WIDTH'(payload + HDR_LEN);
  end

endmodule

// File: rtl/rr_trace_unpacker.sv
// rr_trace_unpacker: re-cuts the densely bit-packed record/replay trace stream
// into variable-width packets {payloads, LOGE bits, LOGB bitmap}.
//   clk, rst                 clock, asynchronous active-high reset
//   in_data/in_valid/in_ready/in_last   trace beats, stream bit 0 = in_data[0]
//   out_data/out_width/out_valid/out_ready  packets, bits >= out_width are zero
//   done                     one-cycle pulse once the trace has fully drained
//   pkt_count, trunc_err     only when RR_UNPACK_STATS_EN is defined: packets
//                            emitted since reset, sticky format/truncation error
module rr_trace_unpacker
  import rr_trace_pkg::*;
#(
  parameter int WIDTH            = 1247,
  parameter int OFFSET_WIDTH     = $clog2(WIDTH-1)+1,
  parameter int AXI_WIDTH        = 512,
  parameter int LOGB_CHANNEL_CNT = 14,
  parameter int LOGE_CHANNEL_CNT = 25,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {
    11'd64, 11'd120, 11'd24, 11'd48, 11'd200, 11'd72, 11'd16,
    11'd256, 11'd8, 11'd96, 11'd32, 11'd128, 11'd64, 11'd80}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXI_WIDTH-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  output logic [WIDTH-1:0]        out_data,
  output logic [OFFSET_WIDTH-1:0] out_width,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    done
`ifdef RR_UNPACK_STATS_EN
  ,
  output logic [31:0]             pkt_count,
  output logic                    trunc_err
`endif
);

  localparam int HDR    = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
  localparam int BUF_W  = WIDTH + AXI_WIDTH;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] HDR_F  = FILL_W'(HDR);
  localparam logic [FILL_W-1:0] AXI_F  = FILL_W'(AXI_WIDTH);
  localparam logic [FILL_W-1:0] ROOM_F = FILL_W'(WIDTH);

  rr_unpack_state_e state, state_next;

  logic [BUF_W-1:0]            buf_q, buf_next;
  logic [FILL_W-1:0]           fill, fill_base, consumed, len_f;
  logic [LOGB_CHANNEL_CNT-1:0] hdr_bitmap;
  logic [LOGE_CHANNEL_CNT-1:0] hdr_loge;
  logic [OFFSET_WIDTH-1:0]     pkt_len;
  logic [WIDTH-1:0]            pkt_mask;
  logic hdr_avail, hdr_nz, pkt_avail, pop, drop, accept, drain_end;

  assign hdr_bitmap = buf_q[LOGB_CHANNEL_CNT-1:0];
  assign hdr_loge   = buf_q[LOGB_CHANNEL_CNT +: LOGE_CHANNEL_CNT];

  rr_pkt_len_calc #(
    .LOGB_CHANNEL_CNT (LOGB_CHANNEL_CNT),
    .LOGE_CHANNEL_CNT (LOGE_CHANNEL_CNT),
    .OFFSET_WIDTH     (OFFSET_WIDTH),
    .CHANNEL_WIDTHS   (CHANNEL_WIDTHS)
  ) u_len (
    .bitmap (hdr_bitmap),
    .len    (pkt_len)
  );

  // Room check looks only at registered fill, so in_ready never depends on in_valid.
  assign in_ready = (state == RR_RUN) && (fill <= ROOM_F);

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    len_f      = FILL_W'(pkt_len);
    hdr_avail  = fill >= HDR_F;
    hdr_nz     = (hdr_bitmap != '0) || (hdr_loge != '0);
    pkt_avail  = hdr_avail && hdr_nz && (fill >= len_f);
    pop        = pkt_avail && (!out_valid || out_ready);
    // A zero header can only be padding once the final beat is in; earlier it is
    // a format error and its HDR bits are skipped.
    drop       = (state == RR_RUN) && hdr_avail && !hdr_nz;
    accept     = in_valid && in_ready;
    drain_end  = (state == RR_DRAIN) && !pkt_avail;
    pkt_mask   = ~({WIDTH{1'b1}} << pkt_len);
    consumed   = pop ? len_f : (drop ? HDR_F : '0);
    fill_base  = fill - consumed;
    // Bits above fill are always zero, so the new beat is simply OR-ed in just
    // above whatever survives this cycle's pop.
    buf_next   = buf_q >> consumed;
    if (accept) buf_next = buf_next | (BUF_W'(in_data) << fill_base);
    if (accept && in_last) state_next = RR_DRAIN;
    if (drain_end)         state_next = RR_RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RR_RUN;
    else     state <= state_next;
  end

  // NOTE: the bit buffer is a flop array, not a RAM, and must reset: the
  // insertion logic relies on everything above fill being zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q     <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_width <= '0;
      done      <= 1'b0;
    end else begin
      done <= drain_end;
      if (drain_end) begin
        buf_q <= '0;
        fill  <= '0;
      end else begin
        buf_q <= buf_next;
        fill  <= fill_base + (accept ? AXI_F : '0);
      end
      if (pop) begin
        out_data  <= buf_q[WIDTH-1:0] & pkt_mask;
        out_width <= pkt_len;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_UNPACK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= '0;
      trunc_err <= 1'b0;
    end else begin
      if (pop) pkt_count <= pkt_count + 32'd1;
      // A drain that stops on a nonzero header can only mean fill < len.
      if (drop || (drain_end && hdr_avail && hdr_nz)) trunc_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_trace_unpacker.sv
// tb_rr_trace_unpacker: randomized scoreboard bench for rr_trace_unpacker with a
// trace-level reference decoder. Config: AXI_WIDTH=32, LOGB=2, LOGE=2,
// channel widths {4, 40}, WIDTH=48. Stats ports checked when RR_UNPACK_STATS_EN.
module tb_rr_trace_unpacker;
  import rr_trace_pkg::*;

  localparam int AXI   = 32;
  localparam int WIDTH = 48;
  localparam int HDR   = 4;
  localparam int OW    = $clog2(WIDTH-1)+1;
  localparam logic [1:0][RR_CHANNEL_WIDTH_BITS-1:0] CW_P = {11'd40, 11'd4};
  localparam bit [5:0] LAT_V = 6'b011110;
  localparam bit [5:0] LAT_D = 6'b100000;

  logic             clk = 1'b0;
  logic             rst;
  logic [AXI-1:0]   in_data;
  logic             in_valid, in_ready, in_last;
  logic [WIDTH-1:0] out_data;
  logic [OW-1:0]    out_width;
  logic             out_valid, out_ready, done;
`ifdef RR_UNPACK_STATS_EN
  logic [31:0]      pkt_count;
  logic             trunc_err;
`endif

  typedef struct {
    logic [WIDTH-1:0] data;
    int               width;
  } pkt_t;

  pkt_t           exp_q[$];
  bit             stream[$];
  logic [AXI-1:0] beats[$];
  int  cw[2] = '{4, 40};
  int  n_tests = 0, n_fail = 0;
  int  done_seen = 0, done_exp = 0, exp_pkts = 0;
  bit  exp_trunc = 1'b0;
  bit  gaps = 1'b0;
  int  rdy_mode = 0;   // 0 random, 1 always ready, 2 stalled

  rr_trace_unpacker #(
    .WIDTH            (WIDTH),
    .AXI_WIDTH        (AXI),
    .LOGB_CHANNEL_CNT (2),
    .LOGE_CHANNEL_CNT (2),
    .CHANNEL_WIDTHS   (CW_P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_width (out_width),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
`ifdef RR_UNPACK_STATS_EN
    ,
    .pkt_count (pkt_count),
    .trunc_err (trunc_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic append_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) stream.push_back(v[i]);
  endtask

  // hdr[1:0] = bitmap, hdr[3:2] = logE; payloads in ascending bitmap index.
  task automatic add_packet(input int hdr);
    append_bits(64'(hdr), HDR);
    for (int c = 0; c < 2; c++)
      if (((hdr >> c) & 1) != 0) append_bits({$urandom, $urandom}, cw[c]);
  endtask

  // Pad with zeros up to a beat boundary, or cut down to one (truncated tail).
  task automatic finalize_trace(input bit pad);
    int nb;
    nb = pad ? (stream.size() + AXI - 1) / AXI : stream.size() / AXI;
    if (nb == 0) nb = 1;
    while (stream.size() < nb * AXI) stream.push_back(1'b0);
    while (stream.size() > nb * AXI) void'(stream.pop_back());
    beats.delete();
    for (int b = 0; b < nb; b++) begin
      logic [AXI-1:0] w;
      for (int i = 0; i < AXI; i++) w[i] = stream[b*AXI + i];
      beats.push_back(w);
    end
  endtask

  // Reference decoder over the whole trace: cut packets until the bits run out,
  // a zero header (padding) is met, or a packet is incomplete (error).
  task automatic model_decode();
    int   pos, n, bm, le, len;
    pkt_t p;
    pos = 0;
    n   = stream.size();
    while (n - pos >= HDR) begin
      bm = int'(stream[pos]) + 2 * int'(stream[pos+1]);
      le = int'(stream[pos+2]) + 2 * int'(stream[pos+3]);
      if (bm == 0 && le == 0) break;
      len = HDR;
      for (int c = 0; c < 2; c++) if (((bm >> c) & 1) != 0) len += cw[c];
      if (n - pos < len) begin
        exp_trunc = 1'b1;
        break;
      end
      p.data = '0;
      for (int i = 0; i < len; i++) p.data[i] = stream[pos + i];
      p.width = len;
      exp_q.push_back(p);
      exp_pkts++;
      pos += len;
    end
  endtask

  // Enters and leaves at posedge+1; the accepting edge is the one just passed.
  task automatic send_beats(input int count, input bit with_last);
    bit acc;
    for (int b = 0; b < count; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = beats[b];
      in_last  = with_last && (b == count - 1);
      acc = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      check("beat_accept", 64'(acc), 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (done_seen < done_exp && c < 1000) begin @(negedge clk); c++; end
    check("done_pulses", 64'(done_seen), 64'(done_exp));
    c = 0;
    while (exp_q.size() != 0 && c < 1000) begin @(negedge clk); c++; end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef RR_UNPACK_STATS_EN
    check("trunc_err", 64'(trunc_err), 64'(exp_trunc));
    check("pkt_count", 64'(pkt_count), 64'(exp_pkts));
`endif
    @(posedge clk); #1;
  endtask

  task automatic run_trace(input bit pad);
    finalize_trace(pad);
    model_decode();
    done_exp++;
    send_beats(beats.size(), 1'b1);
    wait_done();
  endtask

  // One beat of 0xA1 bytes: four 8-bit packets back to back, then done.
  task automatic run_a1();
    pkt_t p;
    stream.delete();
    append_bits(64'hA1A1A1A1, AXI);
    finalize_trace(1'b1);
    p.data  = 48'hA1;
    p.width = 8;
    repeat (4) exp_q.push_back(p);
    exp_pkts += 4;
    done_exp++;
    rdy_mode = 1;
    gaps     = 1'b0;
    @(posedge clk); #1;
    send_beats(1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("a1_out_valid", 64'(out_valid), 64'(LAT_V[k]));
      check("a1_done", 64'(done), 64'(LAT_D[k]));
    end
    @(posedge clk); #1;
    wait_done();
    rdy_mode = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_width", 64'(out_width), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef RR_UNPACK_STATS_EN
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_trunc_err", 64'(trunc_err), 64'd0);
`endif
  endtask

  // out_ready generator.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every packet handshake, counts done pulses.
  initial begin : monitor
    pkt_t p;
    forever begin
      @(negedge clk);
      if (done) done_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pkt_unexpected: got width %0d data %0h, expected none", out_width, out_data);
        end else begin
          p = exp_q.pop_front();
          check("pkt_width", 64'(out_width), 64'(p.width));
          check("pkt_data", 64'(out_data), 64'(p.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Four 8-bit packets from one beat.
    run_a1();

    // One 44-bit packet spanning two beats.
    stream.delete();
    add_packet(6);
    run_trace(1'b1);

    // Output stalled under continuous beats: input backpressure, nothing lost.
    stream.delete();
    while (stream.size() < 320) add_packet($urandom_range(1, 15));
    finalize_trace(1'b1);
    model_decode();
    done_exp++;
    gaps = 1'b0;
    fork
      send_beats(beats.size(), 1'b1);
      begin
        rdy_mode = 2;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        rdy_mode = 0;
      end
    join
    wait_done();

    // Full packets followed by 4 zero pad bits: no error.
    stream.delete();
    add_packet(6); add_packet(1); add_packet(13);
    run_trace(1'b1);

    // Trailing header 4'b0010 with only 8 payload bits: dropped, error.
    stream.delete();
    add_packet(6); add_packet(5);
    append_bits(64'b0010, HDR);
    append_bits(64'($urandom), 8);
    run_trace(1'b1);

    // Reset in the middle of a packet spanning two beats.
    stream.delete();
    add_packet(6);
    finalize_trace(1'b1);
    send_beats(1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_trunc = 1'b0;
    exp_pkts  = 0;
    run_a1();

    // Randomized traces: random packets, random gaps, padded or cut tails.
    for (int t = 0; t < 40; t++) begin
      int np;
      np = $urandom_range(2, 12);
      stream.delete();
      gaps = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < np; k++) add_packet($urandom_range(1, 15));
      run_trace($urandom_range(0, 1) == 1);
    end

    check("total_done", 64'(done_seen), 64'(done_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
